// File: rtl/param_fifo_if.sv
// Handshake and status bundle for param_fifo: write/read requests, read data
// and occupancy/error flags.
interface param_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);
  logic                   clear;
  logic                   we;
  logic [WIDTH-1:0]       data;
  logic                   rd;
  logic [WIDTH-1:0]       dataout;
  logic                   dataout_valid;
  logic                   full;
  logic                   empty;
  logic                   almost_full;
  logic                   almost_empty;
  logic [$clog2(DEPTH):0] count;
  logic                   overflow;
  logic                   underflow;

  modport master (
    output clear, we, data, rd,
    input  dataout, dataout_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  clear, we, data, rd,
    output dataout, dataout_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/param_fifo.sv
// Single-clock synchronous FIFO with registered read data, occupancy count,
// almost-full/empty thresholds and sticky overflow/underflow flags.
module param_fifo #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input logic           clk,
  input logic           reset,
  param_fifo_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] dout_p1;
  logic             vld_p1;
  logic             ovf_q;
  logic             udf_q;
  logic             rd_acc;
  logic             wr_acc;

  // Flags decode only registered occupancy, never the live requests.
  assign bus.full         = (count_q == CW'(DEPTH));
  assign bus.empty        = (count_q == '0);
  assign bus.almost_full  = (count_q >= CW'(AF_LEVEL));
  assign bus.almost_empty = (count_q <= CW'(AE_LEVEL));
  assign bus.count        = count_q;
  assign bus.dataout      = dout_p1;
  assign bus.dataout_valid = vld_p1;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;

  // A write at full is still taken when a read frees a slot the same cycle.
  always_comb begin
    rd_acc = bus.rd & ~bus.empty;
    wr_acc = bus.we & (~bus.full | rd_acc);
  end

  always_ff @(posedge clk) begin
    if (reset && !bus.clear && wr_acc) mem[wr_ptr] <= bus.data;
  end

  // Read stage: one register between accepted rd and dataout/dataout_valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      dout_p1 <= '0;
      vld_p1  <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else if (bus.clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      vld_p1  <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      vld_p1 <= rd_acc;
      if (rd_acc) begin
        dout_p1 <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (wr_acc && !rd_acc)      count_q <= count_q + 1'b1;
      else if (rd_acc && !wr_acc) count_q <= count_q - 1'b1;
      if (bus.we && !wr_acc) ovf_q <= 1'b1;
      if (bus.rd && !rd_acc) udf_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_param_fifo.sv
// Self-checking bench for param_fifo: directed scenarios plus randomized
// traffic against a queue-based reference model.
module tb_param_fifo;
  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  param_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  param_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] m_dout;
  logic             m_vld;
  logic             m_ovf;
  logic             m_udf;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_dout = '0;
    m_vld  = 1'b0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".dout"},  64'(bus.dataout), 64'(m_dout));
    chk({tag, ".vld"},   64'(bus.dataout_valid), 64'(m_vld));
    chk({tag, ".count"}, 64'(bus.count), 64'(q.size()));
    chk({tag, ".full"},  64'(bus.full), 64'(q.size() == DEPTH));
    chk({tag, ".empty"}, 64'(bus.empty), 64'(q.size() == 0));
    chk({tag, ".af"},    64'(bus.almost_full), 64'(q.size() >= AF));
    chk({tag, ".ae"},    64'(bus.almost_empty), 64'(q.size() <= AE));
    chk({tag, ".ovf"},   64'(bus.overflow), 64'(m_ovf));
    chk({tag, ".udf"},   64'(bus.underflow), 64'(m_udf));
  endtask

  // Drive one cycle from a falling edge, advance the model at the rising
  // edge, and compare on the next falling edge.
  task automatic step(input string tag, input logic c, input logic w,
                      input logic [WIDTH-1:0] d, input logic r);
    bit racc, wacc;
    bus.clear = c;
    bus.we    = w;
    bus.data  = d;
    bus.rd    = r;
    @(posedge clk);
    if (c) begin
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
      m_vld = 1'b0;
    end else begin
      racc = r && (q.size() > 0);
      wacc = w && ((q.size() < DEPTH) || racc);
      if (r && !racc) m_udf = 1'b1;
      if (w && !wacc) m_ovf = 1'b1;
      m_vld = racc;
      if (racc) m_dout = q.pop_front();
      if (wacc) q.push_back(d);
    end
    @(negedge clk);
    bus.clear = 1'b0;
    bus.we    = 1'b0;
    bus.rd    = 1'b0;
    check_all(tag);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset     = 1'b0;
    bus.clear = 1'b0;
    bus.we    = 1'b0;
    bus.rd    = 1'b0;
    bus.data  = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all("reset");
    reset = 1'b1;

    // Fill, overflow, drain in order
    for (int i = 1; i <= 8; i++) begin
      step("fill", 1'b0, 1'b1, WIDTH'(i), 1'b0);
      if (i == 6) chk("af_at6", 64'(bus.almost_full), 64'd1);
    end
    chk("full_at8", 64'(bus.full), 64'd1);
    step("ovf", 1'b0, 1'b1, 8'hFF, 1'b0);
    chk("ovf_set", 64'(bus.overflow), 64'd1);
    for (int i = 1; i <= 8; i++) begin
      step("drain", 1'b0, 1'b0, '0, 1'b1);
      chk("drain_val", 64'(bus.dataout), 64'(i));
    end
    step("clr1", 1'b1, 1'b0, '0, 1'b0);

    // Interleaved traffic across pointer wrap
    for (int i = 0; i < 12; i++)
      step("wrap", 1'b0, 1'b1, WIDTH'(8'h10 + i), i >= 3);
    for (int i = 0; i < 4; i++) step("wrapdrain", 1'b0, 1'b0, '0, 1'b1);
    chk("wrap_last", 64'(bus.dataout), 64'h1B);

    // Simultaneous read and write at full
    for (int i = 0; i < 8; i++) step("fill2", 1'b0, 1'b1, WIDTH'(8'h20 + i), 1'b0);
    step("rwfull", 1'b0, 1'b1, 8'hA5, 1'b1);
    chk("rwfull_dout", 64'(bus.dataout), 64'h20);
    chk("rwfull_cnt", 64'(bus.count), 64'd8);
    for (int i = 0; i < 8; i++) step("drain2", 1'b0, 1'b0, '0, 1'b1);
    chk("a5_last", 64'(bus.dataout), 64'hA5);

    // Underflow and no fall-through on empty
    step("clr2", 1'b1, 1'b0, '0, 1'b0);
    step("udf", 1'b0, 1'b0, '0, 1'b1);
    chk("udf_set", 64'(bus.underflow), 64'd1);
    step("rw_empty", 1'b0, 1'b1, 8'h3C, 1'b1);
    chk("rw_empty_vld", 64'(bus.dataout_valid), 64'd0);
    step("rd3c", 1'b0, 1'b0, '0, 1'b1);
    chk("rd3c_val", 64'(bus.dataout), 64'h3C);

    // Clear with pending data and sticky error flag
    for (int i = 0; i < 5; i++) step("load5", 1'b0, 1'b1, WIDTH'(8'h40 + i), 1'b0);
    for (int i = 0; i < 4; i++) step("over", 1'b0, 1'b1, WIDTH'(8'h50 + i), 1'b0);
    step("clr3", 1'b1, 1'b1, 8'h77, 1'b1);
    chk("clr3_cnt", 64'(bus.count), 64'd0);
    chk("clr3_ovf", 64'(bus.overflow), 64'd0);

    // Asynchronous reset between edges
    for (int i = 0; i < 3; i++) step("load3", 1'b0, 1'b1, WIDTH'(8'h60 + i), 1'b0);
    step("rd1", 1'b0, 1'b0, '0, 1'b1);
    step("wr1", 1'b0, 1'b1, 8'h63, 1'b0);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    reset = 1'b1;
    step("post_rst", 1'b0, 1'b0, '0, 1'b0);
    step("post_rst_rd", 1'b0, 1'b0, '0, 1'b1);

    // Randomized traffic with shifting read/write bias
    for (int i = 0; i < 2000; i++) begin
      int wb, rb;
      wb = ((i / 200) % 2 == 0) ? 70 : 35;
      rb = ((i / 200) % 2 == 0) ? 35 : 70;
      step("rand", ($urandom_range(0, 199) == 0),
           ($urandom_range(0, 99) < wb),
           WIDTH'($urandom),
           ($urandom_range(0, 99) < rb));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/param_fifo.md
PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits (1..64).
REQ-002 Parameter DEPTH, default 8, number of entries; power of two, 2..1024.
REQ-003 Parameter AF_LEVEL, default DEPTH-2, almost_full threshold (1..DEPTH).
REQ-004 Parameter AE_LEVEL, default 2, almost_empty threshold (0..DEPTH-1).
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 clear  input  1  synchronous flush request.
REQ-008 we  input  1  write request.
REQ-009 data  input  WIDTH  write data.
REQ-010 rd  input  1  read request.
REQ-011 dataout  output  WIDTH  registered read data.
REQ-012 dataout_valid  output  1  one-cycle pulse: dataout holds newly read word.
REQ-013 full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-014 count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-015 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-016 Storage SHALL be a DEPTH x WIDTH array addressed by write and read pointers of $clog2(DEPTH) bits, wrapping DEPTH-1 -> 0 modulo DEPTH.
REQ-017 Write accepted when we=1 and (full=0 or read accepted same cycle); accepted write stores data at write pointer, increments write pointer.
REQ-018 Read accepted when rd=1 and empty=0; accepted read loads mem[read pointer] into dataout next edge, increments read pointer, dataout_valid=1 for that one cycle.
REQ-019 No read accepted: dataout SHALL hold its value, dataout_valid=0.
REQ-020 Read latency: exactly one clock from accepted rd to dataout_valid; no fall-through when empty (write+read on empty: write accepted, read rejected).
REQ-021 count: +1 on write only, -1 on read only, unchanged on simultaneous accepted read+write (including at full).
REQ-022 full=(count==DEPTH), empty=(count==0), almost_full=(count>=AF_LEVEL), almost_empty=(count<=AE_LEVEL); all decoded from registered state, no combinational path from rd/we/data.
REQ-023 we=1 rejected (full, no accepted read): data dropped, no state change, overflow set to 1.
REQ-024 rd=1 on empty: no state change, dataout held, underflow set to 1.
REQ-025 overflow/underflow remain 1 until reset or clear.
REQ-026 clear=1: next edge pointers and count to 0, overflow/underflow to 0, dataout_valid to 0, dataout held; rd/we ignored that cycle (clear has priority).
REQ-027 Data order strictly first-in first-out across pointer wrap-around.

Reset
REQ-028 reset=0 asynchronously: pointers=0, count=0, dataout=0, dataout_valid=0, overflow=0, underflow=0; flags thus empty=1, full=0, almost_empty=1, almost_full=0.
REQ-029 Memory array contents SHALL NOT be reset; reads only return written data.
REQ-030 Reset deasserted synchronously to clk by the integrator; first operation accepted on the first rising edge with reset=1.
REQ-031 Reset mid-operation discards all stored entries; no dataout_valid pulse follows.

Verification (WIDTH=8, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2)
REQ-032 Write 0x01..0x08 on 8 edges -> count=8, full=1, almost_full=1 after 6th write; 9th write 0xFF -> overflow=1, count=8; read 8 -> dataout 0x01..0x08 in order, each one cycle after rd.
REQ-033 Write 12 words 0x10..0x1B interleaved with reads keeping count<=4 -> read sequence exactly 0x10..0x1B across pointer wrap.
REQ-034 At full, rd=1 and we=1 with data 0xA5 -> count stays 8, dataout=oldest word, 0xA5 read last after 7 further reads.
REQ-035 Empty, rd=1 -> underflow=1, dataout_valid=0, dataout unchanged; empty with rd=1,we=1 data 0x3C -> count=1, no valid pulse, next read returns 0x3C.
REQ-036 Load 5 words, set overflow by filling then writing, assert clear with rd=1,we=1 -> count=0, empty=1, overflow=0, no valid pulse.
REQ-037 Assert reset=0 between clock edges with count=3 -> outputs take reset values immediately, before next edge.
